// File: rtl/approx_error_sweeper.sv
// approx_error_sweeper: steps every (A,B) operand pair through an external
// exact-vs-approximate multiplier comparator and gathers error statistics.
// Ports: clk, rst (async, active high), start/abort controls, A_out/B_out
// operands to the comparator, err_in absolute error from it, busy/done
// status, and the statistics outputs err_sum, err_max, max_A, max_B,
// nz_count, sample_count and err_sq_sum.
// Build option: define APPROX_SQERR_EN to accumulate err_in squared into
// err_sq_sum. Without it err_sq_sum reads 0 and no multiplier is built.
module approx_error_sweeper #(
  parameter int N     = 8,
  parameter int SUM_W = 4*N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [N-1:0]       A_out,
  output logic [N-1:0]       B_out,
  input  logic [2*N-1:0]     err_in,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   err_sum,
  output logic [2*N-1:0]     err_max,
  output logic [N-1:0]       max_A,
  output logic [N-1:0]       max_B,
  output logic [2*N:0]       nz_count,
  output logic [2*N:0]       sample_count,
  output logic [6*N-1:0]     err_sq_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] OP_MAX  = '1;
  localparam logic [N-1:0] OP_ONE  = 1;
  localparam logic [2*N:0] CNT_ONE = 1;

  state_t             state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [2*N-1:0]     max_q, max_d;
  logic [N-1:0]       max_a_q, max_a_d;
  logic [N-1:0]       max_b_q, max_b_d;
  logic [2*N:0]       nz_q, nz_d;
  logic [2*N:0]       cnt_q, cnt_d;

`ifdef APPROX_SQERR_EN
  logic [6*N-1:0]     sq_q, sq_d;
  logic [4*N-1:0]     sq_prod;

  assign sq_prod = err_in * err_in;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    max_d   = max_q;
    max_a_d = max_a_q;
    max_b_d = max_b_q;
    nz_d    = nz_q;
    cnt_d   = cnt_q;
`ifdef APPROX_SQERR_EN
    sq_d    = sq_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          a_d     = '0;
          b_d     = '0;
          sum_d   = '0;
          max_d   = '0;
          max_a_d = '0;
          max_b_d = '0;
          nz_d    = '0;
          cnt_d   = '0;
`ifdef APPROX_SQERR_EN
          sq_d    = '0;
`endif
        end
      end
      SWEEP: begin
        if (abort) begin
          // Current pair is dropped; partial stats stay visible.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          sum_d = sum_q + {{(SUM_W-2*N){1'b0}}, err_in};
`ifdef APPROX_SQERR_EN
          sq_d  = sq_q + {{(2*N){1'b0}}, sq_prod};
`endif
          if (err_in != '0) begin
            nz_d = nz_q + CNT_ONE;
          end
          // Strict compare keeps the earliest pair on ties.
          if (err_in > max_q) begin
            max_d   = err_in;
            max_a_d = a_q;
            max_b_d = b_q;
          end
          if (a_q == OP_MAX && b_q == OP_MAX) begin
            state_d = DONE;
          end else begin
            b_d = b_q + OP_ONE;
            if (b_q == OP_MAX) begin
              a_d = a_q + OP_ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
      nz_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      max_a_q <= max_a_d;
      max_b_q <= max_b_d;
      nz_q    <= nz_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef APPROX_SQERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q <= '0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign err_sq_sum = sq_q;
`else
  assign err_sq_sum = '0;
`endif

  assign A_out        = a_q;
  assign B_out        = b_q;
  assign busy         = (state_q == SWEEP);
  assign done         = (state_q == DONE);
  assign err_sum      = sum_q;
  assign err_max      = max_q;
  assign max_A        = max_a_q;
  assign max_B        = max_b_q;
  assign nz_count     = nz_q;
  assign sample_count = cnt_q;

endmodule

// File: doc/approx_error_sweeper.md
Name: approx_error_sweeper

Overview:
- Driving and collecting end of the exact-vs-approximate multiplier comparison interface.
- Sequentially drives every operand pair (A,B) into a comparator instance, samples the absolute error it returns, and accumulates error statistics for readout on the Nexys4 board.
- Sits between the board control logic (start/abort buttons, display) and the combinational comparator.

Parameters:
- N, 8, operand width; must be ≥2 and must match the comparator's N.
- SUM_W, 4*N, width of the error-sum accumulator; holds 2^(2N) samples of (2N)-bit error without overflow.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE or DONE; begins a sweep.
- abort  input  1  level; in SWEEP forces return to IDLE.
- A_out  output  N  operand A to comparator, registered.
- B_out  output  N  operand B to comparator, registered.
- err_in  input  2N  comparator absolute error for current A_out/B_out; combinational path.
- busy  output  1  high while in SWEEP.
- done  output  1  high in DONE; held until next start.
- err_sum  output  SUM_W  sum of err_in over all sampled pairs.
- err_max  output  2N  largest err_in sampled.
- max_A  output  N  A_out at first occurrence of err_max.
- max_B  output  N  B_out at first occurrence of err_max.
- nz_count  output  2N+1  number of pairs with err_in ≠ 0.
- sample_count  output  2N+1  number of pairs sampled.
- err_sq_sum  output  6N  sum of err_in²; see Optional Feature.

Behaviour:
- Reset (async, any state): state=IDLE; every output and accumulator = 0.
- States: IDLE, SWEEP, DONE.
- IDLE --start--> SWEEP.
- DONE --start--> SWEEP; done drops on the same edge.
- On entering SWEEP:
  - A_out=B_out=0.
  - All accumulators and sample_count cleared to 0.
  - busy=1 from the next cycle.
- Each SWEEP cycle, on the clock edge:
  - err_in is sampled for the current (A_out,B_out).
  - sample_count += 1; err_sum += err_in.
  - nz_count += 1 if err_in≠0.
  - If err_in > err_max (strict), update err_max/max_A/max_B. Ties keep the earliest pair in sweep order.
- Sweep order: B_out increments each cycle. When B_out wraps from 2^N-1 to 0, A_out increments.
- Final pair (2^N-1, 2^N-1): accumulated on its edge, then state→DONE, busy=0, done=1, A_out/B_out hold.
- Sweep length is exactly 2^(2N) cycles in SWEEP; final sample_count = 2^(2N).
- start while in SWEEP is ignored.
- abort in SWEEP takes priority over accumulation:
  - Returns to IDLE; that cycle's err_in is not accumulated.
  - Partial statistics hold; done stays 0.
- abort outside SWEEP has no effect.
- start and abort both high in IDLE/DONE: start wins.
- Arithmetic is unsigned throughout. Accumulator widths are chosen so that no overflow is possible; no saturation logic is needed.
- Stats outputs are registers and change only in SWEEP or on entry to SWEEP.

Optional Feature:
- Macro APPROX_SQERR_EN.
- Defined: err_sq_sum accumulates err_in*err_in (4N-bit product, zero-extended) alongside err_sum, under the same clear/abort/accumulate rules. The multiply is combinational in the accumulate path.
- Undefined: err_sq_sum is tied to 0 and no multiplier is instantiated. Port list is identical in both builds.

Test Plan:
- N=2 with a real comparator (truncating 2 LSBs, so approx=0 and err=A*B); pulse start → done after 16 SWEEP cycles; err_sum=36, err_max=9, max_A=3, max_B=3, nz_count=9, sample_count=16; with APPROX_SQERR_EN, err_sq_sum=196, otherwise 0.
- N=8 with a real comparator; full sweep → busy for 65536 cycles, sample_count=65536, err_max=1521 at (255,255), err_sum matches the bench model.
- N=2 with a bench err_in model; abort asserted on the 6th SWEEP cycle (pair (1,1)) → IDLE, sample_count=5, done=0; next start → clean full sweep with the same results as the first scenario.
- N=2 with stub err_in held constant at 4 → err_max=4 held at max_A=0, max_B=0 (tie rule), nz_count=16, err_sum=64.
- rst asserted asynchronously mid-sweep (between edges) → all outputs 0 immediately, state IDLE; start asserted during SWEEP and start+abort together in DONE behave per priority rules.
